// File: rtl/right_shift_agc.sv
// Automatic gain control for the right_shifter: one shift decision per window of valid samples.
// Optional macro RIGHT_SHIFT_AGC_STATS_EN adds up_count/down_count step counters.
module right_shift_agc #(
  parameter int TOTAL_WIDTH = 48,
  parameter int OUT_WIDTH   = 16,
  parameter int LOG_WINDOW  = 10,
  parameter int HOLDOFF     = 4,
  parameter int SHIFT_MAX   = 32,
  parameter int INIT_SHIFT  = 16,
  localparam int SW         = $clog2(TOTAL_WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [TOTAL_WIDTH-1:0] din,
  input  logic                   din_valid,
  input  logic                   enable,
  input  logic                   manual,
  input  logic [SW-1:0]          manual_shift,
  input  logic                   ovf_clear,
  output logic [SW-1:0]          shift,
  output logic                   shift_update,
  output logic                   window_done,
`ifdef RIGHT_SHIFT_AGC_STATS_EN
  output logic [31:0]            up_count,
  output logic [31:0]            down_count,
`endif
  output logic                   ovf
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    DECIDE = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t                 state_r;
  logic [LOG_WINDOW-1:0]  cnt_r;
  logic [HW-1:0]          hold_r;
  logic [TOTAL_WIDTH-2:0] peak_r;

  logic [TOTAL_WIDTH-2:0] mag_s;
  logic                   accept_s;
  logic                   ovf_hit_s;
  logic                   hi_s;
  logic                   lo_s;
  logic                   abort_s;
  logic [SW-1:0]          man_sat_s;

  // Sample magnitude, window thresholds and saturated manual shift.
  always_comb begin
    // Ones-complement magnitude avoids the -min overflow of a true absolute value.
    mag_s     = din[TOTAL_WIDTH-2:0] ^ {(TOTAL_WIDTH-1){din[TOTAL_WIDTH-1]}};
    accept_s  = (state_r == ACQ) && din_valid;
    ovf_hit_s = accept_s && (|mag_s[TOTAL_WIDTH-2:OUT_WIDTH-1]);
    hi_s      = |peak_r[TOTAL_WIDTH-2:OUT_WIDTH-1];
    lo_s      = ~|peak_r[TOTAL_WIDTH-2:OUT_WIDTH-3];
    abort_s   = manual || !enable;
    if (manual_shift > SW'(SHIFT_MAX)) begin
      man_sat_s = SW'(SHIFT_MAX);
    end else begin
      man_sat_s = manual_shift;
    end
  end

  // Control FSM with registered shift, pulses, sticky overflow and optional step counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r      <= IDLE;
      shift        <= SW'(INIT_SHIFT);
      cnt_r        <= '0;
      hold_r       <= '0;
      peak_r       <= '0;
      ovf          <= 1'b0;
      shift_update <= 1'b0;
      window_done  <= 1'b0;
`ifdef RIGHT_SHIFT_AGC_STATS_EN
      up_count     <= 32'd0;
      down_count   <= 32'd0;
`endif
    end else begin
      shift_update <= 1'b0;
      window_done  <= 1'b0;

      if (ovf_hit_s) begin
        ovf <= 1'b1;
      end else if (ovf_clear) begin
        ovf <= 1'b0;
      end

      // Manual override wins everywhere; non-IDLE states also abort to IDLE below.
      if (manual) begin
        shift <= man_sat_s;
      end

      case (state_r)
        IDLE: begin
          if (enable && !manual) begin
            state_r <= ACQ;
            cnt_r   <= '0;
            peak_r  <= '0;
          end
        end
        ACQ: begin
          if (abort_s) begin
            state_r <= IDLE;
          end else if (din_valid) begin
            peak_r <= peak_r | mag_s;
            if (cnt_r == '1) begin
              state_r     <= DECIDE;
              window_done <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        DECIDE: begin
          cnt_r  <= '0;
          peak_r <= '0;
          hold_r <= '0;
          if (abort_s) begin
            state_r <= IDLE;
          end else if (hi_s && (shift < SW'(SHIFT_MAX))) begin
            shift        <= shift + 1'b1;
            shift_update <= 1'b1;
            state_r      <= SETTLE;
`ifdef RIGHT_SHIFT_AGC_STATS_EN
            up_count     <= up_count + 32'd1;
`endif
          end else if (lo_s && (shift != '0)) begin
            shift        <= shift - 1'b1;
            shift_update <= 1'b1;
            state_r      <= SETTLE;
`ifdef RIGHT_SHIFT_AGC_STATS_EN
            down_count   <= down_count + 32'd1;
`endif
          end else begin
            state_r <= ACQ;
          end
        end
        SETTLE: begin
          // Hold-off is time based so the shifter pipeline drains regardless of din_valid.
          if (abort_s) begin
            state_r <= IDLE;
          end else if (hold_r == HW'(HOLDOFF - 1)) begin
            state_r <= ACQ;
          end else begin
            hold_r <= hold_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
